// File: rtl/reg_file_nr_pkg.sv
// Shared definitions for the accumulator-ISA register file: named-register
// offsets, the fixed 16-entry indices and the Bits-register flag positions.
package reg_file_nr_pkg;

    // Named-register indices for the 16-entry file.
    localparam int R_ACC  = 15;
    localparam int R_BCMP = 14;
    localparam int R_BTGT = 13;
    localparam int R_BITS = 12;
    localparam int R_ONE  = 11;
    localparam int R_ZERO = 10;

    // Flag positions inside the Bits register.
    localparam int CarryOutBit  = 0;
    localparam int CarryInBit   = 1;
    localparam int BranchDirBit = 3;

    // Named registers counted down from the top of the file.
    localparam int REG_OFS_ACC  = 1;
    localparam int REG_OFS_BCMP = 2;
    localparam int REG_OFS_BTGT = 3;
    localparam int REG_OFS_BITS = 4;
    localparam int REG_OFS_ONE  = 5;
    localparam int REG_OFS_ZERO = 6;

    // Index of a named register in a file of nregs entries.
    function automatic int reg_idx(input int nregs, input int ofs);
        return nregs - ofs;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: constant Zero/One, stored value, or the
// register's next-state value when bypass is enabled and allowed.
module rf_read_port
    import reg_file_nr_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit BYPASS   = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored   [NUM_REGS],
    input  logic [DATA_W-1:0] next_val [NUM_REGS],
    input  logic              bypass_ok,
    output logic [DATA_W-1:0] data
);

    localparam int IDX_ONE  = reg_idx(NUM_REGS, REG_OFS_ONE);
    localparam int IDX_ZERO = reg_idx(NUM_REGS, REG_OFS_ZERO);

    // Constants first, then forwarded next-state or the stored value.
    always_comb begin
        data = stored[addr];
        if (addr == ADDR_W'(IDX_ZERO)) begin
            data = '0;
        end else if (addr == ADDR_W'(IDX_ONE)) begin
            data = DATA_W'(1);
        end else if (BYPASS && bypass_ok) begin
            data = next_val[addr];
        end
    end

endmodule

// File: rtl/reg_file_nr.sv
// Parametrised register file: general read/write ports, dedicated
// accumulator write, Bits flag updates, named taps, optional read bypass
// and a registered read-only-violation pulse.
module reg_file_nr
    import reg_file_nr_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16,
    parameter bit BYPASS   = 1'b1,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] acc_q,
    output logic [DATA_W-1:0] bcmp_q,
    output logic [DATA_W-1:0] btgt_q,
    output logic [DATA_W-1:0] bits_q,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              acc_we,
    input  logic [DATA_W-1:0] acc_wdata,
    input  logic              cout_we,
    input  logic              cout_d,
    input  logic              bdir_we,
    input  logic              bdir_d,
    output logic              ro_err
);

    localparam int IDX_ACC  = reg_idx(NUM_REGS, REG_OFS_ACC);
    localparam int IDX_BCMP = reg_idx(NUM_REGS, REG_OFS_BCMP);
    localparam int IDX_BTGT = reg_idx(NUM_REGS, REG_OFS_BTGT);
    localparam int IDX_BITS = reg_idx(NUM_REGS, REG_OFS_BITS);
    localparam int IDX_ONE  = reg_idx(NUM_REGS, REG_OFS_ONE);
    localparam int IDX_ZERO = reg_idx(NUM_REGS, REG_OFS_ZERO);

    logic [DATA_W-1:0] stored   [NUM_REGS];
    logic [DATA_W-1:0] next_val [NUM_REGS];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == IDX_ZERO) begin : g_zero
            assign stored[i]   = '0;
            assign next_val[i] = '0;
        end else if (i == IDX_ONE) begin : g_one
            assign stored[i]   = DATA_W'(1);
            assign next_val[i] = DATA_W'(1);
        end else begin : g_rw
            logic              hit;
            logic [DATA_W-1:0] q;
            logic [DATA_W-1:0] d;

            assign hit = wr_en && (wr_addr == ADDR_W'(i));

            if (i == IDX_ACC) begin : g_acc
                // ALU result beats the general port on a collision.
                always_comb begin
                    d = q;
                    if (acc_we) begin
                        d = acc_wdata;
                    end else if (hit) begin
                        d = wr_data;
                    end
                end
            end else if (i == IDX_BITS) begin : g_bits
                // General write forms the base; flag writes override only their own bits.
                always_comb begin
                    d = hit ? wr_data : q;
                    if (cout_we) d[CarryOutBit]  = cout_d;
                    if (bdir_we) d[BranchDirBit] = bdir_d;
                end
            end else begin : g_plain
                assign d = hit ? wr_data : q;
            end

            // Storage update; reset drops any pending write.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q <= '0;
                end else begin
                    q <= d;
                end
            end

            assign stored[i]   = q;
            assign next_val[i] = d;
        end
    end

    // Flag any general write aimed at a constant register, one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ro_err <= 1'b0;
        end else begin
            ro_err <= wr_en && ((wr_addr == ADDR_W'(IDX_ZERO)) ||
                                (wr_addr == ADDR_W'(IDX_ONE)));
        end
    end

    assign acc_q  = stored[IDX_ACC];
    assign bcmp_q = stored[IDX_BCMP];
    assign btgt_q = stored[IDX_BTGT];
    assign bits_q = stored[IDX_BITS];

    rf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .BYPASS   (BYPASS)
    ) u_port_a (
        .addr      (rd_addr_a),
        .stored    (stored),
        .next_val  (next_val),
        .bypass_ok (rst_n),
        .data      (rd_data_a)
    );

    rf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .BYPASS   (BYPASS)
    ) u_port_b (
        .addr      (rd_addr_b),
        .stored    (stored),
        .next_val  (next_val),
        .bypass_ok (rst_n),
        .data      (rd_data_b)
    );

endmodule

// File: tb/tb_reg_file_nr.sv
// Directed bench for reg_file_nr: a bypassing and a non-bypassing 16x8 file
// share stimulus; a 32x16 file covers the width/depth generalisation.
module tb_reg_file_nr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Shared stimulus for the two 16x8 instances.
    logic [3:0] rd_addr_a, rd_addr_b, wr_addr;
    logic [7:0] wr_data, acc_wdata;
    logic       wr_en, acc_we, cout_we, cout_d, bdir_we, bdir_d;

    logic [7:0] b_rd_a, b_rd_b, b_acc, b_bcmp, b_btgt, b_bits;
    logic       b_ro;
    logic [7:0] n_rd_a, n_rd_b, n_acc, n_bcmp, n_btgt, n_bits;
    logic       n_ro;

    // 32x16 instance.
    logic [4:0]  w_rd_addr_a, w_rd_addr_b, w_wr_addr;
    logic [15:0] w_wr_data, w_acc_wdata;
    logic        w_wr_en, w_acc_we, w_cout_we, w_cout_d, w_bdir_we, w_bdir_d;
    logic [15:0] w_rd_a, w_rd_b, w_acc, w_bcmp, w_btgt, w_bits;
    logic        w_ro;

    reg_file_nr #(.DATA_W(8), .NUM_REGS(16), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(b_rd_a), .rd_data_b(b_rd_b), .acc_q(b_acc), .bcmp_q(b_bcmp),
        .btgt_q(b_btgt), .bits_q(b_bits), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .acc_we(acc_we), .acc_wdata(acc_wdata),
        .cout_we(cout_we), .cout_d(cout_d), .bdir_we(bdir_we), .bdir_d(bdir_d),
        .ro_err(b_ro)
    );

    reg_file_nr #(.DATA_W(8), .NUM_REGS(16), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(n_rd_a), .rd_data_b(n_rd_b), .acc_q(n_acc), .bcmp_q(n_bcmp),
        .btgt_q(n_btgt), .bits_q(n_bits), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .acc_we(acc_we), .acc_wdata(acc_wdata),
        .cout_we(cout_we), .cout_d(cout_d), .bdir_we(bdir_we), .bdir_d(bdir_d),
        .ro_err(n_ro)
    );

    reg_file_nr #(.DATA_W(16), .NUM_REGS(32), .BYPASS(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n), .rd_addr_a(w_rd_addr_a), .rd_addr_b(w_rd_addr_b),
        .rd_data_a(w_rd_a), .rd_data_b(w_rd_b), .acc_q(w_acc), .bcmp_q(w_bcmp),
        .btgt_q(w_btgt), .bits_q(w_bits), .wr_en(w_wr_en), .wr_addr(w_wr_addr),
        .wr_data(w_wr_data), .acc_we(w_acc_we), .acc_wdata(w_acc_wdata),
        .cout_we(w_cout_we), .cout_d(w_cout_d), .bdir_we(w_bdir_we), .bdir_d(w_bdir_d),
        .ro_err(w_ro)
    );

    typedef struct {
        logic       wr_en;
        logic [3:0] wr_addr;
        logic [7:0] wr_data;
        logic       acc_we;
        logic [7:0] acc_wdata;
        logic       cout_we, cout_d, bdir_we, bdir_d;
        logic [3:0] rd_a;
        logic [7:0] exp_rd_a_byp;  // same cycle, bypassing file
        logic [7:0] exp_rd_a_nb;   // same cycle, non-bypassing file
        logic [7:0] exp_rd_b_byp;  // rd_b fixed at Acc
        logic [7:0] exp_acc, exp_bcmp, exp_btgt, exp_bits;  // after the edge
        logic       exp_ro;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic we, input logic [3:0] wa, input logic [7:0] wd,
        input logic aw, input logic [7:0] ad,
        input logic cw, input logic cd, input logic bw, input logic bd,
        input logic [3:0] ra, input logic [7:0] ea_b, input logic [7:0] ea_n,
        input logic [7:0] eb_b, input logic [7:0] eacc, input logic [7:0] ebcmp,
        input logic [7:0] ebtgt, input logic [7:0] ebits, input logic ero);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
        v.acc_we = aw; v.acc_wdata = ad;
        v.cout_we = cw; v.cout_d = cd; v.bdir_we = bw; v.bdir_d = bd;
        v.rd_a = ra; v.exp_rd_a_byp = ea_b; v.exp_rd_a_nb = ea_n; v.exp_rd_b_byp = eb_b;
        v.exp_acc = eacc; v.exp_bcmp = ebcmp; v.exp_btgt = ebtgt; v.exp_bits = ebits;
        v.exp_ro = ero;
        return v;
    endfunction

    task automatic idle_inputs();
        wr_en = 0; wr_addr = 0; wr_data = 0; acc_we = 0; acc_wdata = 0;
        cout_we = 0; cout_d = 0; bdir_we = 0; bdir_d = 0;
        w_wr_en = 0; w_wr_addr = 0; w_wr_data = 0; w_acc_we = 0; w_acc_wdata = 0;
        w_cout_we = 0; w_cout_d = 0; w_bdir_we = 0; w_bdir_d = 0;
    endtask

    vec_t vecs[16];

    initial begin
        // Table starts from the all-zero post-reset state; rd_b stays at Acc.
        //               we wa    wd     aw ad     cw cd bw bd ra    rd_a byp  rd_a nb   rd_b   acc    bcmp   btgt   bits   ro
        vecs[0]  = mk(1, 4'd15, 8'hAA, 1, 8'h3C, 0, 0, 0, 0, 4'd15, 8'h3C, 8'h00, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00, 0);
        vecs[1]  = mk(1, 4'd12, 8'h00, 0, 8'h00, 1, 1, 1, 1, 4'd12, 8'h09, 8'h00, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'h09, 0);
        vecs[2]  = mk(1, 4'd12, 8'hFF, 0, 8'h00, 0, 0, 0, 0, 4'd12, 8'hFF, 8'h09, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'hFF, 0);
        vecs[3]  = mk(1, 4'd10, 8'h77, 0, 8'h00, 0, 0, 0, 0, 4'd10, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'hFF, 1);
        vecs[4]  = mk(0, 4'd0,  8'h00, 0, 8'h00, 0, 0, 0, 0, 4'd10, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'hFF, 0);
        vecs[5]  = mk(1, 4'd5,  8'h12, 0, 8'h00, 0, 0, 0, 0, 4'd5,  8'h12, 8'h00, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'hFF, 0);
        vecs[6]  = mk(1, 4'd11, 8'h00, 0, 8'h00, 0, 0, 0, 0, 4'd11, 8'h01, 8'h01, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'hFF, 1);
        vecs[7]  = mk(1, 4'd14, 8'h5A, 0, 8'h00, 0, 0, 0, 0, 4'd5,  8'h12, 8'h12, 8'h3C, 8'h3C, 8'h5A, 8'h00, 8'hFF, 0);
        vecs[8]  = mk(1, 4'd13, 8'hC3, 0, 8'h00, 0, 0, 0, 0, 4'd14, 8'h5A, 8'h5A, 8'h3C, 8'h3C, 8'h5A, 8'hC3, 8'hFF, 0);
        vecs[9]  = mk(0, 4'd0,  8'h00, 0, 8'h00, 1, 0, 1, 1, 4'd12, 8'hFE, 8'hFF, 8'h3C, 8'h3C, 8'h5A, 8'hC3, 8'hFE, 0);
        vecs[10] = mk(0, 4'd0,  8'h00, 1, 8'h81, 0, 0, 0, 0, 4'd15, 8'h81, 8'h3C, 8'h81, 8'h81, 8'h5A, 8'hC3, 8'hFE, 0);
        vecs[11] = mk(1, 4'd15, 8'h44, 0, 8'h00, 0, 0, 0, 0, 4'd15, 8'h44, 8'h81, 8'h44, 8'h44, 8'h5A, 8'hC3, 8'hFE, 0);
        vecs[12] = mk(1, 4'd12, 8'h00, 0, 8'h00, 1, 1, 1, 0, 4'd12, 8'h01, 8'hFE, 8'h44, 8'h44, 8'h5A, 8'hC3, 8'h01, 0);
        vecs[13] = mk(1, 4'd5,  8'h34, 0, 8'h00, 0, 0, 0, 0, 4'd5,  8'h34, 8'h12, 8'h44, 8'h44, 8'h5A, 8'hC3, 8'h01, 0);
        vecs[14] = mk(1, 4'd5,  8'h56, 0, 8'h00, 0, 0, 0, 0, 4'd5,  8'h56, 8'h34, 8'h44, 8'h44, 8'h5A, 8'hC3, 8'h01, 0);
        vecs[15] = mk(0, 4'd0,  8'h00, 0, 8'h00, 0, 0, 0, 0, 4'd5,  8'h56, 8'h56, 8'h44, 8'h44, 8'h5A, 8'hC3, 8'h01, 0);

        // Reset held with a write pending: it must be ignored and not forwarded.
        idle_inputs();
        rst_n = 0;
        wr_en = 1; wr_addr = 4'd3; wr_data = 8'h55;
        rd_addr_a = 4'd3; rd_addr_b = 4'd11;
        w_rd_addr_a = 5'd27; w_rd_addr_b = 5'd26;
        @(posedge clk); @(posedge clk); #1;
        check("byp_off_in_reset", b_rd_a, 8'h00);
        @(negedge clk);
        rst_n = 1; idle_inputs();
        #1;
        check("rst_reg3_byp", b_rd_a, 8'h00);
        check("rst_reg3_nb", n_rd_a, 8'h00);
        check("rst_one", b_rd_b, 8'h01);
        check("rst_acc", b_acc, 8'h00);
        check("rst_bcmp", b_bcmp, 8'h00);
        check("rst_btgt", b_btgt, 8'h00);
        check("rst_bits", b_bits, 8'h00);
        check("rst_ro", b_ro, 1'b0);
        check("w_rst_one", w_rd_a, 16'h0001);
        check("w_rst_zero", w_rd_b, 16'h0000);
        check("w_rst_acc", w_acc, 16'h0000);
        rd_addr_a = 4'd10; #1;
        check("rst_zero", b_rd_a, 8'h00);

        // Table-driven pass: same-cycle reads, then taps and ro_err after the edge.
        rd_addr_b = 4'd15;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
            acc_we = vecs[i].acc_we; acc_wdata = vecs[i].acc_wdata;
            cout_we = vecs[i].cout_we; cout_d = vecs[i].cout_d;
            bdir_we = vecs[i].bdir_we; bdir_d = vecs[i].bdir_d;
            rd_addr_a = vecs[i].rd_a;
            #1;
            check($sformatf("v%0d_rd_a_byp", i), b_rd_a, vecs[i].exp_rd_a_byp);
            check($sformatf("v%0d_rd_a_nb", i), n_rd_a, vecs[i].exp_rd_a_nb);
            check($sformatf("v%0d_rd_b_byp", i), b_rd_b, vecs[i].exp_rd_b_byp);
            @(posedge clk); #1;
            check($sformatf("v%0d_acc", i), b_acc, vecs[i].exp_acc);
            check($sformatf("v%0d_bcmp", i), b_bcmp, vecs[i].exp_bcmp);
            check($sformatf("v%0d_btgt", i), b_btgt, vecs[i].exp_btgt);
            check($sformatf("v%0d_bits", i), b_bits, vecs[i].exp_bits);
            check($sformatf("v%0d_ro", i), b_ro, vecs[i].exp_ro);
            check($sformatf("v%0d_bits_nb", i), n_bits, vecs[i].exp_bits);
            check($sformatf("v%0d_ro_nb", i), n_ro, vecs[i].exp_ro);
        end

        // Reset mid-operation: pending writes (incl. to One) are dropped entirely.
        @(negedge clk);
        rst_n = 0;
        wr_en = 1; wr_addr = 4'd11; wr_data = 8'h99;
        acc_we = 1; acc_wdata = 8'h11;
        cout_we = 1; cout_d = 1;
        rd_addr_a = 4'd5;
        @(posedge clk); #1;
        check("midrst_acc", b_acc, 8'h00);
        check("midrst_bits", b_bits, 8'h00);
        check("midrst_bcmp", b_bcmp, 8'h00);
        check("midrst_reg5", b_rd_a, 8'h00);
        @(negedge clk);
        rst_n = 1; idle_inputs();
        #1;
        check("midrst_ro", b_ro, 1'b0);

        // 32x16 file: Acc at 31, flags land on bits 0 and 3 of Bits at 28.
        @(negedge clk);
        w_wr_en = 1; w_wr_addr = 5'd31; w_wr_data = 16'hBEEF;
        w_cout_we = 1; w_cout_d = 1; w_bdir_we = 1; w_bdir_d = 1;
        w_rd_addr_a = 5'd31; w_rd_addr_b = 5'd28;
        #1;
        check("w_byp_acc", w_rd_a, 16'hBEEF);
        check("w_byp_bits", w_rd_b, 16'h0009);
        check("w_acc_before", w_acc, 16'h0000);
        @(posedge clk); #1;
        check("w_acc", w_acc, 16'hBEEF);
        check("w_bits", w_bits, 16'h0009);
        @(negedge clk);
        w_wr_en = 1; w_wr_addr = 5'd27; w_wr_data = 16'h1234;
        w_cout_we = 0; w_bdir_we = 0;
        w_rd_addr_a = 5'd27;
        #1;
        check("w_one_const", w_rd_a, 16'h0001);
        @(posedge clk); #1;
        check("w_ro", w_ro, 1'b1);
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        check("w_ro_clear", w_ro, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
